msrv32_imem_slave: RTL and testbench

Instruction-side AHB-Lite memory slave for the msrv32 core: the responder at the far end of the fetch interface driven by the PC stage. It samples the fetch address, inserts a configurable number of wait states via its ready output, and returns the addressed 32-bit instruction word from an internal word-addressed array. A side write port preloads the array (boot loader / testbench), and optional error signalling covers bad fetch addresses.

---
 rtl/msrv32_imem_slave.sv | 204 ++++++++++++++++++++
 tb/tb_msrv32_imem_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_imem_slave.sv
// -----------------------------------------------------------------------------
// msrv32_imem_slave
//
// Instruction-side AHB-Lite memory slave for the msrv32 core. It sits at the
// far end of the fetch interface that the PC stage drives. The slave accepts a
// fetch address and can stretch the data phase with WAIT_STATES wait states.
// It returns the addressed 32-bit word from an internal word-addressed array.
// A side write port preloads the array for a boot loader or a testbench.
//
// Parameters
//   DEPTH_WORDS  array depth in 32-bit words (power of two, 16..65536)
//   WAIT_STATES  data-phase wait states per fetch (0..7)
//   BASE_ADDR    byte address of word 0 (aligned to DEPTH_WORDS*4)
//
// Ports
//   clk_in         single clock, all logic on the rising edge
//   rst_in         synchronous active-low reset
//   i_addr_in      fetch byte address from the PC stage
//   i_req_in       address-phase valid (NONSEQ transfer)
//   instr_out      fetched instruction; valid while ahb_ready_out=1 in a data phase
//   ahb_ready_out  HREADY back to the PC stage/core
//   ahb_resp_out   HRESP: 0 OKAY, 1 ERROR
//   wr_en_in       preload write strobe (never stalled)
//   wr_addr_in     preload byte address; bits [1:0] ignored
//   wr_data_in     preload data word
//
// Build option
//   MSRV32_IMEM_ERR_EN  when this macro is defined, an accepted address that
//                       is misaligned or outside the array gets a two-cycle
//                       ERROR response. When it is undefined, ahb_resp_out is
//                       tied to 0 and out-of-range addresses alias through
//                       index truncation.
// -----------------------------------------------------------------------------
module msrv32_imem_slave #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] i_addr_in,
   input  logic        i_req_in,
   output logic [31:0] instr_out,
   output logic        ahb_ready_out,
   output logic        ahb_resp_out,
   input  logic        wr_en_in,
   input  logic [31:0] wr_addr_in,
   input  logic [31:0] wr_data_in
);

   localparam int unsigned AW  = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;   // addi x0, x0, 0
   localparam logic [2:0]  WS  = 3'(WAIT_STATES);

   // IDLE : ready, no data phase pending (also the zero-wait data phase)
   // WAIT : data phase stretched, counter running
   // ERR1 : first error cycle  (ready=0, resp=1)
   // ERR2 : second error cycle (ready=1, resp=1); accepts a new request
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR1 = 2'd2,
      ERR2 = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [AW-1:0]   idx_q, idx_d;      // index of the fetch held in WAIT
   logic            rd_en;
   logic [AW-1:0]   rd_idx;

   logic [31:0]     mem [DEPTH_WORDS];

   // ---------------------------------------------------------------------------
   // Address to word-index mapping. The subtraction relative to BASE_ADDR
   // happens in full width. The index is then truncated, so out-of-range
   // addresses alias when the error path is compiled out.
   // ---------------------------------------------------------------------------
   logic [31:0]     fetch_off;
   logic [31:0]     wr_off;
   logic [AW-1:0]   fetch_idx;
   logic [AW-1:0]   wr_idx;
   logic            fetch_bad;

   assign fetch_off = i_addr_in  - BASE_ADDR;
   assign wr_off    = wr_addr_in - BASE_ADDR;
   assign fetch_idx = fetch_off[AW+1:2];
   assign wr_idx    = wr_off[AW+1:2];

`ifdef MSRV32_IMEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
   // Out of range means a nonzero offset above the array window. Addresses
   // below BASE_ADDR wrap to large offsets and are caught by the same test.
   assign fetch_bad = (i_addr_in[1:0] != 2'b00) || (fetch_off[31:AW+2] != '0);
`else
   localparam bit ERR_EN = 1'b0;
   assign fetch_bad = 1'b0;
`endif

   // The byte-lane bits and the bits above the window are not used in every
   // build. They are collected here on purpose.
   logic unused_off_bits;
   assign unused_off_bits = ^{fetch_off[1:0], fetch_off[31:AW+2],
                              wr_off[1:0],    wr_off[31:AW+2]};

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default before the case statement.
   // Without the defaults, a path that skips a signal would infer a latch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      rd_en         = 1'b0;
      rd_idx        = fetch_idx;
      ahb_ready_out = 1'b1;
      ahb_resp_out  = 1'b0;

      case (state_q)
         IDLE, ERR2: begin
            // Ready is high in both states, so this cycle can accept an
            // address phase. ERR2 is the completing error cycle.
            ahb_resp_out = ERR_EN && (state_q == ERR2);
            state_d      = IDLE;
            if (i_req_in) begin
               if (fetch_bad) begin
                  state_d = ERR1;
               end else if (WS == 3'd0) begin
                  // Zero-wait: read at the accepting edge, data next cycle.
                  rd_en  = 1'b1;
                  rd_idx = fetch_idx;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WS;
                  idx_d   = fetch_idx;
               end
            end
         end

         WAIT: begin
            // The address and request are ignored here because the core holds
            // them. The read fires on the edge where the counter reaches 0.
            // Ready comes back the cycle after that edge.
            ahb_ready_out = 1'b0;
            rd_idx        = idx_q;
            if (cnt_q <= 3'd1) begin
               rd_en   = 1'b1;
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         ERR1: begin
            // No array read. instr_out keeps its last value through both
            // error cycles.
            ahb_ready_out = 1'b0;
            ahb_resp_out  = ERR_EN;
            state_d       = ERR2;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, counter and read-data registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. This is what
   // gives read-before-write: instr_out samples mem[] before the preload
   // write from the same edge lands.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         idx_q     <= '0;
         instr_out <= NOP;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         if (rd_en) begin
            instr_out <= mem[rd_idx];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Preload write port
   // ---------------------------------------------------------------------------
   // NOTE: the array has no reset. Clearing it would rule out a plain RAM
   // macro, and the boot loader always writes before the core fetches.
   // Writes also go through while rst_in is low, so preload can overlap reset.
   always_ff @(posedge clk_in) begin
      if (wr_en_in) begin
         mem[wr_idx] <= wr_data_in;
      end
   end

endmodule

// File: tb/tb_msrv32_imem_slave.sv
// -----------------------------------------------------------------------------
// tb_msrv32_imem_slave
//
// Directed, self-checking bench for msrv32_imem_slave. It runs three
// instances that share clock, reset and the preload port: zero wait states,
// two wait states and three wait states. The bench pushes expected fetch
// data into a scoreboard queue when it drives a request. It pops that data
// when the addressed instance presents a ready-high data cycle. The expected
// words come from a small copy of the preloaded contents kept in the bench.
// -----------------------------------------------------------------------------
module tb_msrv32_imem_slave;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   logic        req0, req2, req3;
   logic [31:0] addr0, addr2, addr3;
   logic [31:0] instr0, instr2, instr3;
   logic        rdy0, rdy2, rdy3;
   logic        resp0, resp2, resp3;

   logic [31:0] model [0:3];
   logic [31:0] sb_q [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   msrv32_imem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
      .clk_in(clk), .rst_in(rst_in), .i_addr_in(addr0), .i_req_in(req0),
      .instr_out(instr0), .ahb_ready_out(rdy0), .ahb_resp_out(resp0),
      .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data));

   msrv32_imem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_ws2 (
      .clk_in(clk), .rst_in(rst_in), .i_addr_in(addr2), .i_req_in(req2),
      .instr_out(instr2), .ahb_ready_out(rdy2), .ahb_resp_out(resp2),
      .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data));

   msrv32_imem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
      .clk_in(clk), .rst_in(rst_in), .i_addr_in(addr3), .i_req_in(req3),
      .instr_out(instr3), .ahb_ready_out(rdy3), .ahb_resp_out(resp3),
      .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
      end else begin
         exp = sb_q.pop_front();
         check(tag, obs, exp);
      end
   endtask

   // Global bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset with requests pending ----------------
      rst_in = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      req0 = 1'b1; addr0 = 32'h4;
      req2 = 1'b1; addr2 = 32'h4;
      req3 = 1'b1; addr3 = 32'h4;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_instr0", instr0, NOP);
      check("rst_rdy0",   32'(rdy0),  32'd1);
      check("rst_resp0",  32'(resp0), 32'd0);
      check("rst_instr2", instr2, NOP);
      check("rst_rdy2",   32'(rdy2),  32'd1);
      check("rst_rdy3",   32'(rdy3),  32'd1);
      req0 = 1'b0; req2 = 1'b0; req3 = 1'b0;
      rst_in = 1'b1;
      @(negedge clk);
      check("post_rst_instr0", instr0, NOP);
      check("post_rst_rdy2",   32'(rdy2), 32'd1);
      check("post_rst_instr3", instr3, NOP);

      // ---------------- preload words 0..3 ----------------
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'b1;
         wr_addr = 32'(i * 4);
         wr_data = 32'hA000_0000 + 32'(i);
         model[i[1:0]] = wr_data;
         @(negedge clk);
      end
      wr_en = 1'b0;

      // ---------------- zero wait states, back-to-back ----------------
      for (int i = 0; i < 4; i++) begin
         req0  = 1'b1;
         addr0 = 32'(i * 4);
         sb_q.push_back(model[i[1:0]]);
         @(negedge clk);
         check_pop($sformatf("ws0_b2b_data%0d", i), instr0);
         check($sformatf("ws0_b2b_rdy%0d", i), 32'(rdy0), 32'd1);
      end
      req0 = 1'b0;
      @(negedge clk);
      check("ws0_idle_hold", instr0, model[3]);
      check("ws0_idle_rdy",  32'(rdy0),  32'd1);
      check("ws0_idle_resp", 32'(resp0), 32'd0);

      // ---------------- two wait states, pipelined second request ----------------
      req2 = 1'b1; addr2 = 32'h4;
      sb_q.push_back(model[1]);
      @(negedge clk);
      check("ws2_a_w1_rdy", 32'(rdy2), 32'd0);
      addr2 = 32'hC;                       // must be ignored while stalled
      @(negedge clk);
      check("ws2_a_w2_rdy", 32'(rdy2), 32'd0);
      @(negedge clk);
      check("ws2_a_rdy", 32'(rdy2), 32'd1);
      check_pop("ws2_a_data", instr2);
      addr2 = 32'h8;                       // accepted on this ready-high edge
      sb_q.push_back(model[2]);
      @(negedge clk);
      check("ws2_b_w1_rdy", 32'(rdy2), 32'd0);
      @(negedge clk);
      check("ws2_b_w2_rdy", 32'(rdy2), 32'd0);
      @(negedge clk);
      check("ws2_b_rdy", 32'(rdy2), 32'd1);
      check_pop("ws2_b_data", instr2);
      req2 = 1'b0;
      @(negedge clk);
      check("ws2_idle_rdy",  32'(rdy2), 32'd1);
      check("ws2_idle_hold", instr2, model[2]);

      // ---------------- three wait states, full latency ----------------
      req3 = 1'b1; addr3 = 32'hC;
      sb_q.push_back(model[3]);
      for (int w = 1; w <= 3; w++) begin
         @(negedge clk);
         check($sformatf("ws3_w%0d_rdy", w), 32'(rdy3), 32'd0);
      end
      req3 = 1'b0;
      @(negedge clk);
      check("ws3_rdy", 32'(rdy3), 32'd1);
      check_pop("ws3_data", instr3);

      // ---------------- same-edge preload write and fetch ----------------
      wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'hDEAD_BEEF;
      req0 = 1'b1; addr0 = 32'h8;
      sb_q.push_back(model[2]);            // read-before-write: old word
      model[2] = 32'hDEAD_BEEF;
      @(negedge clk);
      check_pop("rbw_old", instr0);
      wr_en = 1'b0;
      sb_q.push_back(model[2]);
      @(negedge clk);
      check_pop("rbw_new", instr0);
      req0 = 1'b0;
      @(negedge clk);

`ifdef MSRV32_IMEM_ERR_EN
      // ---------------- error responses ----------------
      req0 = 1'b1; addr0 = 32'h6;
      @(negedge clk);
      check("err_mis_e1_rdy",  32'(rdy0),  32'd0);
      check("err_mis_e1_resp", 32'(resp0), 32'd1);
      check("err_mis_e1_hold", instr0, 32'hDEAD_BEEF);
      req0 = 1'b0;
      @(negedge clk);
      check("err_mis_e2_rdy",  32'(rdy0),  32'd1);
      check("err_mis_e2_resp", 32'(resp0), 32'd1);
      check("err_mis_e2_hold", instr0, 32'hDEAD_BEEF);
      @(negedge clk);
      check("err_mis_done_resp", 32'(resp0), 32'd0);
      req0 = 1'b1; addr0 = 32'h1000;
      @(negedge clk);
      check("err_oor_e1_rdy",  32'(rdy0),  32'd0);
      check("err_oor_e1_resp", 32'(resp0), 32'd1);
      addr0 = 32'h0;                       // held through ERR1, taken in ERR2
      @(negedge clk);
      check("err_oor_e2_rdy",  32'(rdy0),  32'd1);
      check("err_oor_e2_resp", 32'(resp0), 32'd1);
      check("err_oor_e2_hold", instr0, 32'hDEAD_BEEF);
      sb_q.push_back(model[0]);
      @(negedge clk);
      check_pop("err2_accept_data", instr0);
      check("err2_accept_resp", 32'(resp0), 32'd0);
      req0 = 1'b0;
`else
      // ---------------- aliasing without the error path ----------------
      req0 = 1'b1; addr0 = 32'h1000;
      sb_q.push_back(model[0]);
      @(negedge clk);
      check_pop("alias_1000", instr0);
      check("alias_1000_resp", 32'(resp0), 32'd0);
      addr0 = 32'h6;
      sb_q.push_back(model[1]);
      @(negedge clk);
      check_pop("alias_06", instr0);
      check("alias_06_resp", 32'(resp0), 32'd0);
      req0 = 1'b0;
`endif
      @(negedge clk);

      // ---------------- reset in the second wait cycle ----------------
      req3 = 1'b1; addr3 = 32'h0;
      @(negedge clk);
      check("rst_mid_w1_rdy", 32'(rdy3), 32'd0);
      @(negedge clk);
      check("rst_mid_w2_rdy", 32'(rdy3), 32'd0);
      rst_in = 1'b0;
      req3   = 1'b0;
      @(negedge clk);
      check("rst_mid_rdy",   32'(rdy3),  32'd1);
      check("rst_mid_instr", instr3, NOP);
      check("rst_mid_resp",  32'(resp3), 32'd0);
      check("rst_mid_ws0",   instr0, NOP);
      rst_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("rst_mid_nolate_instr%0d", k), instr3, NOP);
         check($sformatf("rst_mid_nolate_rdy%0d", k), 32'(rdy3), 32'd1);
      end

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
